// File: rtl/idct_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : idct_pkg                                                    |
// | Function : shared widths, cosine constants and FSM states for idct_2d  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package idct_pkg;

    localparam int c_Y_W       = 9;
    localparam int c_X_W       = 9;
    localparam int c_MID_W     = 16;
    localparam int c_MID_FRAC  = 3;
    localparam int c_COEF_FRAC = 12;

    // C(k)/2*cos(k*pi/16) in Q16; entry 0 is C(0)/2, numerically equal to entry 4
    localparam int c_COS_Q16 [8] = '{23170, 32138, 30274, 27246, 23170, 18205, 12540, 6393};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROW  = 2'd1,
        ST_COL  = 2'd2,
        ST_DONE = 2'd3
    } idct_state_t;

    // Signed basis weight C(k)/2*cos((2n+1)k*pi/16) rounded to FRAC fractional bits
    function automatic int idct_basis(input int n, input int k, input int frac);
        int m;
        int sgn;
        int mag;
        m   = ((2 * n + 1) * k) % 32;
        sgn = 1;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            sgn = -1;
        end
        if (frac >= 16) mag = c_COS_Q16[m] <<< (frac - 16);
        else            mag = (c_COS_Q16[m] + (1 <<< (15 - frac))) >>> (16 - frac);
        return sgn * mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idct_2d_1d_8pt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : idct_1d_8pt                                                 |
// | Function : combinational 8-point IDCT, half-up rounded to OUT_FRAC     |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module idct_1d_8pt
    import idct_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int IN_FRAC   = 3,
    parameter int OUT_FRAC  = 3,
    parameter int OUT_W     = 16,
    parameter int COEF_FRAC = 12
) (
    input  logic [7:0][IN_W-1:0]  i_d,
    output logic [7:0][OUT_W-1:0] o_d
);

    localparam int c_ACC_W = IN_W + COEF_FRAC + 3;
    localparam int c_SHIFT = IN_FRAC + COEF_FRAC - OUT_FRAC;
    localparam int c_RND   = 1 <<< (c_SHIFT - 1);

    for (genvar n = 0; n < 8; n++) begin : g_out
        logic signed [c_ACC_W-1:0] w_prod [8];
        logic signed [c_ACC_W-1:0] w_acc;

        for (genvar k = 0; k < 8; k++) begin : g_term
            localparam int c_B = idct_basis(n, k, COEF_FRAC);
            assign w_prod[k] = c_ACC_W'($signed(i_d[k])) * c_ACC_W'(c_B);
        end

        // Rounding bias folded into the accumulator seed
        always_comb begin
            w_acc = c_ACC_W'(c_RND);
            for (int i = 0; i < 8; i++) begin
                w_acc = w_acc + w_prod[i];
            end
        end

        assign o_d[n] = OUT_W'(w_acc >>> c_SHIFT);
    end

endmodule
`default_nettype wire

// File: rtl/idct_2d.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : idct_2d                                                     |
// | Function : 8x8 inverse DCT, row then column pass on one shared 1D core |
// |            IDCT_SAT_EN: saturate outputs, otherwise wrap to 9 bits     |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module idct_2d
    import idct_pkg::*;
#(
    parameter int COEF_FRAC = c_COEF_FRAC,
    parameter int MID_FRAC  = c_MID_FRAC,
    parameter int MID_W     = c_MID_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [63:0][c_Y_W-1:0] y,
    input  logic                   IN_START,
    output logic [63:0][c_X_W-1:0] x,
    output logic                   OUT_XFC
);

    localparam int c_HALF = 1 <<< (MID_FRAC - 1);

    idct_state_t             r_state;
    idct_state_t             w_state_nxt;
    logic [2:0]              r_cnt;
    logic [63:0][c_Y_W-1:0]  r_y_in;
    logic [63:0][MID_W-1:0]  r_tbuf;
    logic [63:0][c_X_W-1:0]  r_x;
    logic                    r_xfc;
    logic [7:0][MID_W-1:0]   w_din;
    logic [7:0][MID_W-1:0]   w_res;
    logic [7:0][c_X_W-1:0]   w_xs;

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (IN_START)      w_state_nxt = ST_ROW;
            ST_ROW:  if (r_cnt == 3'd7) w_state_nxt = ST_COL;
            ST_COL:  if (r_cnt == 3'd7) w_state_nxt = ST_DONE;
            ST_DONE:                    w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Row pass reads the captured coefficients scaled to MID_FRAC, column pass the buffer
    for (genvar k = 0; k < 8; k++) begin : g_mux
        localparam logic [2:0] c_K = 3'(k);
        assign w_din[k] = (r_state == ST_ROW)
                        ? MID_W'($signed(r_y_in[{r_cnt, c_K}])) <<< MID_FRAC
                        : r_tbuf[{r_cnt, c_K}];
    end

    idct_1d_8pt #(
        .IN_W      (MID_W),
        .IN_FRAC   (MID_FRAC),
        .OUT_FRAC  (MID_FRAC),
        .OUT_W     (MID_W),
        .COEF_FRAC (COEF_FRAC)
    ) u_idct_1d (
        .i_d (w_din),
        .o_d (w_res)
    );

    for (genvar r = 0; r < 8; r++) begin : g_clip
`ifdef IDCT_SAT_EN
        localparam int c_X_MAX = (1 <<< (c_X_W - 1)) - 1;
        localparam int c_X_MIN = -(1 <<< (c_X_W - 1));
        logic signed [MID_W:0] w_int;
        assign w_int = ((MID_W+1)'($signed(w_res[r])) + (MID_W+1)'(c_HALF)) >>> MID_FRAC;
        assign w_xs[r] = (w_int > (MID_W+1)'(c_X_MAX)) ? c_X_W'(c_X_MAX)
                       : (w_int < (MID_W+1)'(c_X_MIN)) ? c_X_W'(c_X_MIN)
                       : w_int[c_X_W-1:0];
`else
        assign w_xs[r] = c_X_W'(((MID_W+1)'($signed(w_res[r])) + (MID_W+1)'(c_HALF)) >>> MID_FRAC);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_y_in <= '0;
            r_tbuf <= '0;
            r_x    <= '0;
            r_xfc  <= 1'b0;
        end else begin
            r_xfc <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (IN_START) r_y_in <= y;
                end
                ST_ROW: begin
                    r_cnt <= r_cnt + 3'd1;
                    for (int c = 0; c < 8; c++) begin
                        r_tbuf[{3'(c), r_cnt}] <= w_res[c];
                    end
                end
                ST_COL: begin
                    r_cnt <= r_cnt + 3'd1;
                    for (int rr = 0; rr < 8; rr++) begin
                        r_x[{3'(rr), r_cnt}] <= w_xs[rr];
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign x       = r_x;
    assign OUT_XFC = r_xfc;

endmodule
`default_nettype wire
